// File: rtl/stream_byte_packer.sv
// Packs an 8-bit byte stream into little-endian DATA_WIDTH-bit stream words.
// Closes packets on in_last or flush and reports each packet's byte count.
module stream_byte_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    t_valid,
  output logic [DATA_WIDTH-1:0]   t_data,
  output logic [DATA_WIDTH/8-1:0] t_strb,
  output logic [DATA_WIDTH/8-1:0] t_keep,
  output logic                    t_last,
  input  logic                    t_ready,
  output logic                    pkt_done,
  output logic [LEN_WIDTH-1:0]    pkt_bytes
);

  localparam int DB = DATA_WIDTH / 8;
  localparam int CW = (DB > 1) ? $clog2(DB) : 1;

  typedef enum logic {IDLE, OPEN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_w;
  logic [LEN_WIDTH-1:0]  run_q, run_d, run_inc;
  logic [LEN_WIDTH-1:0]  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DB-1:0]         strb_d, keep_d, mask;
  logic                  valid_d, last_d;
  logic [CW:0]           fill;
  logic                  byte_acc, flush_acc;
  logic                  full, close, load;

  assign in_ready  = !t_valid || t_ready;
  assign byte_acc  = in_valid && in_ready;
  assign flush_acc = flush && in_ready;

  always_comb begin
    acc_w = acc_q;
    if (byte_acc)
      acc_w[{cnt_q, 3'b000} +: 8] = in_data;
    fill  = {1'b0, cnt_q} + (CW+1)'(byte_acc);
    full  = byte_acc && (fill == (CW+1)'(DB));
    close = flush_acc || (byte_acc && in_last);
    load  = full || close;
    run_inc = run_q;
    if (byte_acc && run_q != '1)
      run_inc = run_q + LEN_WIDTH'(1);
    for (int k = 0; k < DB; k++)
      mask[k] = ((CW+1)'(k) < fill);
  end

  // Output register only reloads when it is empty or draining this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_w;
    run_d   = run_inc;
    pend_d  = pend_q;
    valid_d = t_valid && !t_ready;
    data_d  = t_data;
    strb_d  = t_strb;
    keep_d  = t_keep;
    last_d  = t_last;
    if (byte_acc) begin
      state_d = OPEN;
      cnt_d   = cnt_q + CW'(1);
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = acc_w;
      strb_d  = mask;
      keep_d  = (fill == '0) ? '0 : '1;
      last_d  = close;
      cnt_d   = '0;
      acc_d   = '0;
    end
    if (close) begin
      state_d = IDLE;
      pend_d  = run_inc;
      run_d   = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      run_q     <= '0;
      pend_q    <= '0;
      t_valid   <= 1'b0;
      t_data    <= '0;
      t_strb    <= '0;
      t_keep    <= '0;
      t_last    <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_bytes <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      run_q    <= run_d;
      pend_q   <= pend_d;
      t_valid  <= valid_d;
      t_data   <= data_d;
      t_strb   <= strb_d;
      t_keep   <= keep_d;
      t_last   <= last_d;
      pkt_done <= t_valid && t_ready && t_last;
      if (t_valid && t_ready && t_last)
        pkt_bytes <= pend_q;
    end
  end

  a_in_hold: assert property (
    @(posedge aclk) disable iff (areset)
    in_valid && !in_ready |=> in_valid && $stable(in_data)
  ) else $error("in_valid/in_data changed while stalled");

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer at DATA_WIDTH=64.
// Words and packet counts are captured by a monitor and checked per test.
module tb_stream_byte_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        flush;
  logic        t_valid;
  logic [63:0] t_data;
  logic [7:0]  t_strb;
  logic [7:0]  t_keep;
  logic        t_last;
  logic        t_ready;
  logic        pkt_done;
  logic [31:0] pkt_bytes;

  stream_byte_packer #(.DATA_WIDTH(64), .LEN_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .flush(flush),
    .t_valid(t_valid), .t_data(t_data), .t_strb(t_strb),
    .t_keep(t_keep), .t_last(t_last), .t_ready(t_ready),
    .pkt_done(pkt_done), .pkt_bytes(pkt_bytes)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] wq_data[$];
  logic [7:0]  wq_strb[$];
  logic [7:0]  wq_keep[$];
  logic        wq_last[$];
  logic [31:0] pq[$];

  logic        pv = 0, pr = 0, pa = 1, pl = 0;
  logic [63:0] pd = 0;
  logic [7:0]  ps = 0, pk = 0;
  int          stab_err = 0;
  logic        saw_block = 0;

  // Inputs change 1 time unit after posedge; negedge sees settled values.
  always @(negedge aclk) begin
    if (!areset) begin
      if (t_valid && t_ready) begin
        wq_data.push_back(t_data);
        wq_strb.push_back(t_strb);
        wq_keep.push_back(t_keep);
        wq_last.push_back(t_last);
      end
      if (pkt_done)
        pq.push_back(pkt_bytes);
      if (!in_ready)
        saw_block = 1;
      if (pv && !pr && !pa)
        if (!t_valid || t_data !== pd || t_strb !== ps ||
            t_keep !== pk || t_last !== pl)
          stab_err++;
    end
    pv = t_valid; pr = t_ready; pa = areset;
    pd = t_data; ps = t_strb; pk = t_keep; pl = t_last;
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clr();
    wq_data.delete(); wq_strb.delete();
    wq_keep.delete(); wq_last.delete();
    pq.delete();
  endtask

  task automatic put(input logic [7:0] d, input logic l,
                     input logic f, input logic v);
    in_valid = v; in_data = d; in_last = l; flush = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (in_ready) begin
        @(posedge aclk);
        #1;
        in_valid = 0; in_last = 0; flush = 0;
        return;
      end
    end
    chk("accept_timeout", 1, 0);
    in_valid = 0; in_last = 0; flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1; in_valid = 0; in_data = 0; in_last = 0;
    flush = 0; t_ready = 1;
    step(3);
    chk("rst_valid", t_valid, 0);
    chk("rst_data", t_data, 0);
    chk("rst_strb", t_strb, 0);
    chk("rst_keep", t_keep, 0);
    chk("rst_last", t_last, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_bytes", pkt_bytes, 0);
    chk("rst_ready", in_ready, 1);
    areset = 0;
    step(2);

    // two full words
    clr();
    for (int i = 1; i <= 16; i++)
      put(8'(i), i == 16, 0, 1);
    step(5);
    chk("t1_nwords", wq_data.size(), 2);
    chk("t1_w0", wq_data[0], 64'h0807060504030201);
    chk("t1_s0", wq_strb[0], 8'hFF);
    chk("t1_k0", wq_keep[0], 8'hFF);
    chk("t1_l0", wq_last[0], 0);
    chk("t1_w1", wq_data[1], 64'h100F0E0D0C0B0A09);
    chk("t1_s1", wq_strb[1], 8'hFF);
    chk("t1_l1", wq_last[1], 1);
    chk("t1_npkt", pq.size(), 1);
    chk("t1_bytes", pq[0], 16);

    // partial word closed by in_last
    clr();
    put(8'hA1, 0, 0, 1);
    put(8'hA2, 0, 0, 1);
    put(8'hA3, 1, 0, 1);
    step(5);
    chk("t2_nwords", wq_data.size(), 1);
    chk("t2_w0", wq_data[0], 64'h0000000000A3A2A1);
    chk("t2_s0", wq_strb[0], 8'h07);
    chk("t2_k0", wq_keep[0], 8'hFF);
    chk("t2_l0", wq_last[0], 1);
    chk("t2_bytes", pq[0], 3);

    // full word then flush -> null word
    clr();
    for (int i = 0; i < 8; i++)
      put(8'h11 + 8'(i), 0, 0, 1);
    step(2);
    put(8'h00, 0, 1, 0);
    step(5);
    chk("t3_nwords", wq_data.size(), 2);
    chk("t3_w0", wq_data[0], 64'h1817161514131211);
    chk("t3_l0", wq_last[0], 0);
    chk("t3_w1", wq_data[1], 0);
    chk("t3_s1", wq_strb[1], 0);
    chk("t3_k1", wq_keep[1], 0);
    chk("t3_l1", wq_last[1], 1);
    chk("t3_npkt", pq.size(), 1);
    chk("t3_bytes", pq[0], 8);

    // backpressure
    clr();
    saw_block = 0; stab_err = 0;
    fork
      begin : drv
        for (int i = 0; i < 24; i++)
          put(8'h30 + 8'(i), i == 23, 0, 1);
      end
      begin : stall
        int k;
        k = 0;
        while (!t_valid && k < 200) begin
          @(negedge aclk);
          k++;
        end
        chk("t4_word0_seen", t_valid, 1);
        @(posedge aclk);
        #1;
        t_ready = 0;
        step(10);
        t_ready = 1;
      end
    join
    step(5);
    chk("t4_nwords", wq_data.size(), 3);
    chk("t4_w0", wq_data[0], 64'h3736353433323130);
    chk("t4_w1", wq_data[1], 64'h3F3E3D3C3B3A3938);
    chk("t4_w2", wq_data[2], 64'h4746454443424140);
    chk("t4_l1", wq_last[1], 0);
    chk("t4_l2", wq_last[2], 1);
    chk("t4_block", saw_block, 1);
    chk("t4_stable", stab_err, 0);
    chk("t4_bytes", pq[0], 24);

    // flush while idle -> zero-length packet
    clr();
    put(8'h00, 0, 1, 0);
    step(5);
    chk("t5_nwords", wq_data.size(), 1);
    chk("t5_k0", wq_keep[0], 0);
    chk("t5_s0", wq_strb[0], 0);
    chk("t5_l0", wq_last[0], 1);
    chk("t5_npkt", pq.size(), 1);
    chk("t5_bytes", pq[0], 0);

    // reset with a word pending
    clr();
    t_ready = 0;
    for (int i = 0; i < 8; i++)
      put(8'h70 + 8'(i), 0, 0, 1);
    step(1);
    chk("t6_pending", t_valid, 1);
    areset = 1;
    step(1);
    chk("t6_rst_valid", t_valid, 0);
    chk("t6_rst_strb", t_strb, 0);
    areset = 0;
    t_ready = 1;
    step(2);
    clr();
    put(8'h55, 0, 0, 1);
    put(8'h66, 1, 0, 1);
    step(5);
    chk("t6_nwords", wq_data.size(), 1);
    chk("t6_w0", wq_data[0], 64'h0000000000006655);
    chk("t6_s0", wq_strb[0], 8'h03);
    chk("t6_l0", wq_last[0], 1);
    chk("t6_bytes", pq[0], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
